// File: rtl/vga_sync.sv
// 640x480 @ 60 Hz VGA timing generator: pixel-enable divider, h/v counters and registered sync/strobe decode.
// Optional macro VGA_SYNC_ALIGN_EN adds one register stage on hsync/vsync to line them up with a registered rgb.
module vga_sync #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       videoOn,
    output logic       hsync,
    output logic       vsync,
    output logic       pixelTick,
    output logic       frameStart
);

    localparam int unsigned CW       = 10;
    localparam int unsigned DIV_W    = $clog2(CLK_DIV);
    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_VISIBLE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC - 1;
    localparam int unsigned VS_START = V_VISIBLE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC - 1;

    logic [DIV_W-1:0] div_q, div_d;
    logic [CW-1:0]    x_q, x_d;
    logic [CW-1:0]    y_q, y_d;
    logic             video_q, video_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             tick_q, tick_d;
    logic             frame_q, frame_d;
    logic             tick_c;

    // Next-state counters; decoded outputs are taken from the next state so they align with x/y.
    always_comb begin
        tick_c  = (div_q == DIV_W'(CLK_DIV - 1));
        div_d   = div_q + DIV_W'(1);
        x_d     = x_q;
        y_d     = y_q;
        if (tick_c) begin
            div_d = '0;
            if (x_q == CW'(H_TOTAL - 1)) begin
                x_d = '0;
                if (y_q == CW'(V_TOTAL - 1)) begin
                    y_d = '0;
                end else begin
                    y_d = y_q + CW'(1);
                end
            end else begin
                x_d = x_q + CW'(1);
            end
        end
        video_d = (x_d < CW'(H_VISIBLE)) && (y_d < CW'(V_VISIBLE));
        hsync_d = !((x_d >= CW'(HS_START)) && (x_d <= CW'(HS_END)));
        vsync_d = !((y_d >= CW'(VS_START)) && (y_d <= CW'(VS_END)));
        tick_d  = tick_c;
        frame_d = tick_c && (x_d == '0) && (y_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            video_q <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            tick_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            x_q     <= x_d;
            y_q     <= y_d;
            video_q <= video_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            tick_q  <= tick_d;
            frame_q <= frame_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign videoOn    = video_q;
    assign pixelTick  = tick_q;
    assign frameStart = frame_q;

`ifdef VGA_SYNC_ALIGN_EN
    logic hsync_al_q;
    logic vsync_al_q;

    // Extra stage so syncs reach the pins together with the renderer's registered rgb.
    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_al_q <= 1'b1;
            vsync_al_q <= 1'b1;
        end else begin
            hsync_al_q <= hsync_q;
            vsync_al_q <= vsync_q;
        end
    end

    assign hsync = hsync_al_q;
    assign vsync = vsync_al_q;
`else
    assign hsync = hsync_q;
    assign vsync = vsync_q;
`endif

endmodule

// File: doc/vga_sync.md
# vga_sync

Generates 640x480 @ 60 Hz VGA timing from the 100 MHz system clock and drives the pixel-coordinate inputs of the display renderer. It divides the clock to a 25 MHz pixel enable, runs horizontal and vertical counters, and decodes `x`, `y`, `videoOn`, `hsync`, `vsync`, plus per-pixel and per-frame strobes. It sits directly upstream of the display renderer, which consumes these on the same `clk`.

## Interface
- `CLK_DIV`, 4: system clocks per pixel; must be ≥ 2.
- `H_VISIBLE`, 640: visible pixels per line.
- `H_FP`, 16; `H_SYNC`, 96; `H_BP`, 48: horizontal porches/sync, in pixels. Line total 800.
- `V_VISIBLE`, 480: visible lines.
- `V_FP`, 10; `V_SYNC`, 2; `V_BP`, 33: vertical porches/sync, in lines. Frame total 525.

- `clk`  in  1  system clock, 100 MHz; one clock, synchronous design.
- `reset`  in  1  synchronous, active-high reset.
- `x`  out  10  horizontal count, 0..799.
- `y`  out  10  vertical count, 0..524.
- `videoOn`  out  1  high when x < 640 and y < 480.
- `hsync`  out  1  active-low horizontal sync.
- `vsync`  out  1  active-low vertical sync.
- `pixelTick`  out  1  one-clk strobe on each pixel advance.
- `frameStart`  out  1  one-clk strobe when (x,y) becomes (0,0).

## Operation
- Divider `div` counts 0..CLK_DIV-1 every clk and wraps. A tick occurs in the clk where `div == CLK_DIV-1`.
- On a tick:
  - `x` increments.
  - At `x == 799`, `x` wraps to 0 and `y` increments.
  - At `y == 524` with `x == 799`, `y` also wraps to 0.
- Between ticks, `x` and `y` hold.
- `pixelTick` is registered. It is high in the single clk in which the new `x`/`y` first appear, and low otherwise.
- `frameStart` is high in the same clk as `pixelTick` when the new `(x,y)` is `(0,0)`.
- `videoOn`, `hsync` and `vsync` are registered. They are computed from the next-state counters, so they are valid in the same clk as the `x`/`y` they describe.
- `hsync` is low for x in [656, 751]. `vsync` is low for y in [490, 491]. All bounds come from the parameters: start = VISIBLE+FP, end = VISIBLE+FP+SYNC-1.
- All arithmetic is unsigned 10-bit. Counters never exceed their totals minus 1.

## Timing
- Reset values:
  - `x`=0, `y`=0, `div`=0.
  - `videoOn`=0, `hsync`=1, `vsync`=1.
  - `pixelTick`=0, `frameStart`=0.
- The first tick after reset release comes CLK_DIV clks after the first clk with `reset` low. That tick moves `x` to 1; there is no `frameStart` for the initial (0,0).
- `reset` asserted mid-frame returns every output to its reset value on the next clk edge, with no partial line.
- From (799,524) the next tick gives (0,0) with `frameStart`=1, `videoOn`=1, `hsync`=1, `vsync`=1.
- Line period: 800 × CLK_DIV clks. Frame period: 420000 × CLK_DIV clks (1 680 000 at default).
- Downstream (the renderer) registers `rgb` one clk after sampling `x`/`y`/`videoOn`.

## Configuration
- `VGA_SYNC_ALIGN_EN` defined:
  - `hsync` and `vsync` pass through one extra register (reset value 1).
  - They then lag `x`/`y`/`videoOn` by one clk, matching the renderer's registered `rgb` at the pins.
- Not defined: `hsync`/`vsync` are aligned with `x`/`y`/`videoOn` as described above.

## Test plan
- Reset held 10 clks, then released → all outputs at reset values during reset; first `pixelTick` 4 clks after release, with `x`=1, `y`=0.
- Run one line → `pixelTick` every 4 clks. `videoOn` falls when `x` goes 639→640. `hsync`=0 exactly for x=656..751, i.e. 96 ticks = 384 clks. `x` wraps 799→0 and `y` goes to 1.
- Run one full frame → `vsync`=0 only for y=490..491. `frameStart` is seen exactly once, 1 680 000 clks apart across two frames, with `x`=0, `y`=0.
- `reset` pulsed 1 clk at (x=300, y=200) → next clk `x`=0, `y`=0, `videoOn`=0, `hsync`=1, `vsync`=1. Counting restarts cleanly.
- With `VGA_SYNC_ALIGN_EN`: the falling edge of `hsync` occurs 1 clk after the tick that sets `x`=656. Without the macro: the same clk as that tick.
- Parameter override `CLK_DIV`=2 → `pixelTick` every 2 clks; line period 1600 clks.
